// File: rtl/ram_writer_pkg.sv
// Shared definitions for the ram_writer block: default parameters
// and the sequencing FSM state encoding.
package ram_writer_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int AW_DEFAULT = 4;
    localparam logic [DW_DEFAULT-1:0] CLR_VAL_DEFAULT = 4'b0000;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/ram_writer_mem.sv
// Storage for ram_writer: 2**AW x DW array, one synchronous write
// port and one registered, enabled read port (read-before-write).
// Ports:
//   clk, rst_n                  clock, async active-low reset (read reg only)
//   we_i, waddr_i, wdata_i      write port
//   re_i, raddr_i, rdata_o      registered read port
module ram_writer_mem #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Array is deliberately not reset; its contents come from the sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update yields the old word on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_writer.sv
// RAM writer: init/clear sweep FSM, auto-increment pointer with
// wrap pulse, and write arbitration in front of ram_writer_mem.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   wr_valid/wr_ready, wr_auto,         write request handshake and
//   wr_addr, wr_data, ptr_load          addressing/pointer load
//   clr_start, busy                     clear sweep request / status
//   ptr, wrap                           pointer and wrap pulse
//   rd_en, rd_addr, rd_data             registered read port
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int          DW      = DW_DEFAULT,
    parameter int          AW      = AW_DEFAULT,
    parameter logic [DW-1:0] CLR_VAL = CLR_VAL_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          wr_auto,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          ptr_load,
    input  logic          clr_start,
    output logic          busy,
    output logic [AW-1:0] ptr,
    output logic          wrap,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LAST = '1;

    state_e        state_q, state_d;
    logic [AW-1:0] swp_q, swp_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          wrap_q, wrap_d;

    logic          accept;
    logic          auto_acc;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    assign accept   = (state_q == IDLE) && wr_valid;
    assign auto_acc = accept && wr_auto;

    always_comb begin
        state_d = state_q;
        swp_d   = swp_q;
        we      = 1'b0;
        waddr   = wr_addr;
        wdata   = wr_data;
        unique case (state_q)
            INIT, CLEAR: begin
                we    = 1'b1;
                waddr = swp_q;
                wdata = CLR_VAL;
                swp_d = swp_q + 1'b1;
                if (swp_q == LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (wr_valid) begin
                    we = 1'b1;
                    // A coinciding pointer load redirects the auto write.
                    if (wr_auto && !ptr_load) begin
                        waddr = ptr_q;
                    end
                end
                if (clr_start) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = INIT;
                swp_d   = '0;
            end
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (ptr_load) begin
            ptr_d = wr_addr + {{(AW-1){1'b0}}, auto_acc};
        end else if (auto_acc) begin
            ptr_d  = ptr_q + 1'b1;
            wrap_d = (ptr_q == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            swp_q   <= '0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            swp_q   <= swp_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign ptr      = ptr_q;
    assign wrap     = wrap_q;

    ram_writer_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (rd_en),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_ram_writer.sv
// Scoreboard bench for ram_writer: driver updates a behavioural
// model and queues expected outputs; a monitor compares after each edge.
module tb_ram_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_auto = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       ptr_load = 1'b0;
    logic       clr_start = 1'b0;
    logic       busy;
    logic [3:0] ptr;
    logic       wrap;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;
    logic [3:0] rd_data;

    ram_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_auto   (wr_auto),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ptr_load  (ptr_load),
        .clr_start (clr_start),
        .busy      (busy),
        .ptr       (ptr),
        .wrap      (wrap),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int bsy;
        int p;
        int wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int mem_m[16];
    int ptr_m = 0;
    int busy_m = 16;   // sweep cycles still to run
    int rd_m = 0;
    int wrap_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per clock edge while running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.rd));
                chk("busy", 32'(busy), 32'(e.bsy));
                chk("wr_ready", 32'(wr_ready), 32'(e.bsy == 0));
                chk("ptr", 32'(ptr), 32'(e.p));
                chk("wrap", 32'(wrap), 32'(e.wr));
            end
        end
    end

    // One clock of stimulus, applied at a falling edge.
    task automatic step(input bit vl, input bit au, input int ad, input int dt,
                        input bit ld, input bit cl, input bit re, input int ra);
        exp_t e;
        wr_valid  = vl;
        wr_auto   = au;
        wr_addr   = 4'(ad);
        wr_data   = 4'(dt);
        ptr_load  = ld;
        clr_start = cl;
        rd_en     = re;
        rd_addr   = 4'(ra);
        if (re) rd_m = mem_m[ra];
        wrap_m = 0;
        if (busy_m > 0) begin
            mem_m[16 - busy_m] = 0;
            busy_m--;
            if (ld) ptr_m = ad;
        end else begin
            if (vl) begin
                if (au && !ld) mem_m[ptr_m] = dt;
                else mem_m[ad] = dt;
            end
            if (ld) begin
                ptr_m = (ad + ((vl && au) ? 1 : 0)) % 16;
            end else if (vl && au) begin
                wrap_m = (ptr_m == 15) ? 1 : 0;
                ptr_m = (ptr_m + 1) % 16;
            end
            if (cl) busy_m = 16;
        end
        e.rd = rd_m;
        e.bsy = (busy_m > 0) ? 1 : 0;
        e.p = ptr_m;
        e.wr = wrap_m;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_step(input int a);
        step(0, 0, 0, 0, 0, 0, 1, a);
    endtask

    // Assert reset between edges and check outputs respond at once.
    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 0; ptr_load = 0; clr_start = 0; rd_en = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        busy_m = 16;
        ptr_m = 0;
        rd_m = 0;
        wrap_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (mem_m[i]) mem_m[i] = 0;
        @(negedge clk);
        do_reset();

        // Write held through INIT: exactly one write at ptr 0 once ready.
        while (busy_m > 0) step(1, 1, 0, 9, 0, 0, 0, 0);
        step(1, 1, 0, 9, 0, 0, 0, 0);
        for (int a = 0; a < 16; a++) rd_step(a);
        idle_step();

        // Pointer load then auto writes across the top of the array.
        step(0, 0, 14, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 2, 0, 0, 0, 0);
        step(1, 1, 0, 3, 0, 0, 0, 0);
        rd_step(14);
        rd_step(15);
        rd_step(0);
        idle_step();

        // Same-address read and write: old value first.
        step(1, 0, 5, 4'hA, 0, 0, 1, 5);
        rd_step(5);
        idle_step();

        // Clear with a coinciding write, and a mid-sweep clr_start.
        step(1, 0, 3, 7, 0, 1, 1, 3);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, (i == 8), 1, 3);
        rd_step(3);
        rd_step(5);
        idle_step();

        // Reset during a clear at sweep address 9.
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) idle_step();
        do_reset();
        for (int i = 0; i < 17; i++) rd_step(i % 16);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) != 0, int'($urandom_range(0, 15)));
        end
        for (int a = 0; a < 16; a++) rd_step(a);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_writer.md
RAM_WRITER -- requirements
Module: ram_writer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DW  4  data width in bits.
  AW  4  address width in bits; depth is 2**AW (16).
  CLR_VAL  4'b0000  value written by a clear sweep.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all state updates on its rising edge.
  rst_n  input  1  asynchronous active-low reset.
  wr_valid  input  1  write request.
  wr_ready  output  1  write accepted this cycle when wr_valid=1 and wr_ready=1.
  wr_auto  input  1  1 = write at internal pointer and ignore wr_addr; 0 = write at wr_addr.
  wr_addr  input  AW  explicit write address; also the pointer-load value.
  wr_data  input  DW  write data.
  ptr_load  input  1  load the internal pointer from wr_addr.
  clr_start  input  1  request a full clear sweep.
  busy  output  1  clear sweep in progress.
  ptr  output  AW  current auto-increment pointer.
  wrap  output  1  one-cycle pulse when an auto write at address 2**AW-1 wraps the pointer to 0.
  rd_en  input  1  read enable.
  rd_addr  input  AW  read address.
  rd_data  output  DW  registered read data.

Function
REQ-003 The FSM SHALL have three states, INIT, IDLE and CLEAR.
  INIT is entered on reset.
  INIT and CLEAR each write CLR_VAL to addresses 0..2**AW-1, one per cycle in ascending order (16 cycles), then go to IDLE.
REQ-004 Outputs in each state SHALL be:
  wr_ready = 1 only in IDLE (combinational from state).
  busy = 1 in INIT and CLEAR.
REQ-005 Accepted write addressing SHALL be:
  When wr_auto=1, an accepted write stores wr_data at ptr, and ptr increments modulo 2**AW on the next edge.
  When wr_auto=0, an accepted write stores at wr_addr, and ptr is unchanged.
REQ-006 Write visibility SHALL be as follows: a write accepted in cycle N is visible to a read issued in cycle N+1.
REQ-007 When wrap is asserted, it SHALL be registered and high for exactly one cycle after the edge on which ptr goes from 2**AW-1 to 0 via an auto write.
  ptr_load never asserts wrap.
REQ-008 ptr_load SHALL be honoured in any state and SHALL set ptr to wr_addr.
  If it coincides with an accepted auto write, the write goes to wr_addr and ptr becomes wr_addr+1 (mod 2**AW).
REQ-009 The read path SHALL behave as follows.
  Read is independent of FSM state.
  When rd_en=1, rd_data takes mem[rd_addr] on the next edge (latency 1).
  When rd_en=0, rd_data holds its value.
REQ-010 Same-address read and write in the same cycle (including a clear-sweep write) SHALL return the old contents (read-before-write).
REQ-011 clr_start asserted in INIT or CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-012 clr_start in IDLE together with an accepted write: the write SHALL be performed, and CLEAR starts on the next cycle and later overwrites it.
REQ-013 wr_valid while wr_ready=0 SHALL have no effect on memory or ptr.
  The requester holds wr_valid until it is accepted.
REQ-014 The clear sweep SHALL NOT modify ptr.

Reset
REQ-015 While rst_n=0, outputs SHALL be:
  state = INIT with sweep address 0.
  ptr = 0, wrap = 0, rd_data = 0.
  busy = 1, wr_ready = 0.
REQ-016 Reset asserted mid-sweep or mid-write SHALL abort the operation; the INIT sweep restarts from address 0 after release.
REQ-017 The memory array SHALL NOT be asynchronously reset; its contents are defined only by the INIT sweep.

Structure
REQ-018 A shared package ram_writer_pkg SHALL hold:
  the DW, AW and CLR_VAL defaults;
  the FSM state enumeration (INIT, IDLE, CLEAR).
REQ-019 The storage SHALL be one sub-module, ram_writer_mem.
  2**AW x DW array, one synchronous write port, one registered read port with enable, read-before-write.
  FSM, pointer and arbitration SHALL live in ram_writer.

Verification
REQ-020 Reset then release: busy=1 for exactly 16 cycles, then wr_ready=1; reading addresses 0..15 returns 4'b0000.
REQ-021 ptr_load with wr_addr=4'd14, then auto writes of 4'h1, 4'h2, 4'h3:
  mem[14]=1, mem[15]=2, mem[0]=3;
  wrap pulses once after the second write;
  final ptr=1.
REQ-022 Explicit write of 4'hA to address 5 with a simultaneous read of address 5: rd_data=old value (0) next cycle, then 4'hA on a read the cycle after.
REQ-023 clr_start in IDLE with an accepted write of 4'h7 to address 3:
  busy high for 16 cycles;
  clr_start pulsed mid-sweep has no effect;
  mem[3]=0 afterwards.
REQ-024 rst_n asserted at sweep address 9 of a CLEAR:
  outputs reach reset values immediately;
  after release, INIT runs a full 16 cycles starting at address 0.
REQ-025 wr_valid held high during INIT: no write occurs until wr_ready=1, then exactly one write at ptr=0.
